// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and small helpers for the character-LCD arbiter.
package lcd_pkg;

    localparam logic [7:0] LCD_CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CMD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ADDR_LINE0   = 8'h80;
    localparam logic [7:0] LCD_ADDR_LINE1   = 8'hC0;
    localparam logic [7:0] LCD_CHAR_0       = 8'h30;
    localparam logic [7:0] LCD_CHAR_1       = 8'h31;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_CLEAR = 3'd2,
        ST_ADDR  = 3'd3,
        ST_CHAR  = 3'd4,
        ST_FIN   = 3'd5
    } arb_state_e;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_SETUP = 2'd1,
        WR_PULSE = 2'd2,
        WR_HOLD  = 2'd3
    } wr_phase_e;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = LCD_CMD_FUNC_SET;
            2'd1:    cmd = LCD_CMD_DISP_ON;
            2'd2:    cmd = LCD_CMD_ENTRY;
            default: cmd = LCD_CMD_CLEAR;
        endcase
        return cmd;
    endfunction

    function automatic logic [7:0] bit_char(input logic b);
        return b ? LCD_CHAR_1 : LCD_CHAR_0;
    endfunction

endpackage

// File: rtl/lcd_display_arbiter_if.sv
// Requester handshake plus LCD pin bundle; slave = arbiter side, master = requesters/pins side.
interface lcd_display_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_line;
    logic [16*NUM_REQ-1:0] req_value;
    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REQ-1:0]    done;
    logic                  busy;
    logic                  enable;
    logic [7:0]            lcd_data;
    logic                  rs;
    logic                  rw;
    logic                  on;

    modport slave (
        input  req_valid, req_line, req_value,
        output grant, done, busy, enable, lcd_data, rs, rw, on
    );

    modport master (
        output req_valid, req_line, req_value,
        input  grant, done, busy, enable, lcd_data, rs, rw, on
    );
endinterface

// File: rtl/lcd_bus_writer.sv
// SETUP / PULSE / HOLD timing engine for one LCD bus write; ready also rises in the
// last HOLD cycle so consecutive writes run back to back.
module lcd_bus_writer
    import lcd_pkg::*;
#(
    parameter int PULSE_CYCLES = 12,
    parameter int WAIT_CYCLES  = 2000,
    parameter int CLEAR_WAIT   = 80000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    input  logic       rs_sel,
    input  logic       long_wait,
    output logic       ready,
    output logic       enable,
    output logic [7:0] lcd_data,
    output logic       rs
);

    localparam int MAX_CNT = (CLEAR_WAIT > PULSE_CYCLES) ? CLEAR_WAIT : PULSE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    wr_phase_e        phase_r, phase_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic [7:0]       data_r, data_n;
    logic             rs_r, rs_n;
    logic             long_r, long_n;
    logic             enable_r, enable_n;

    assign ready    = (phase_r == WR_IDLE) || ((phase_r == WR_HOLD) && (cnt_r == CNT_W'(1)));
    assign enable   = enable_r;
    assign lcd_data = data_r;
    assign rs       = rs_r;

    // Phase sequencing and write latching.
    always_comb begin
        phase_n = phase_r;
        cnt_n   = cnt_r;
        data_n  = data_r;
        rs_n    = rs_r;
        long_n  = long_r;
        case (phase_r)
            WR_IDLE: begin
                if (start) begin
                    phase_n = WR_SETUP;
                    data_n  = data;
                    rs_n    = rs_sel;
                    long_n  = long_wait;
                end else begin
                    phase_n = WR_IDLE;
                end
            end
            WR_SETUP: begin
                phase_n = WR_PULSE;
                cnt_n   = CNT_W'(PULSE_CYCLES);
            end
            WR_PULSE: begin
                if (cnt_r == CNT_W'(1)) begin
                    phase_n = WR_HOLD;
                    cnt_n   = long_r ? CNT_W'(CLEAR_WAIT) : CNT_W'(WAIT_CYCLES);
                end else begin
                    cnt_n = cnt_r - CNT_W'(1);
                end
            end
            WR_HOLD: begin
                if (cnt_r == CNT_W'(1)) begin
                    if (start) begin
                        phase_n = WR_SETUP;
                        data_n  = data;
                        rs_n    = rs_sel;
                        long_n  = long_wait;
                    end else begin
                        phase_n = WR_IDLE;
                    end
                end else begin
                    cnt_n = cnt_r - CNT_W'(1);
                end
            end
            default: phase_n = WR_IDLE;
        endcase
        enable_n = (phase_n == WR_PULSE);
    end

    // Phase/counter state and registered bus pins.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase_r  <= WR_IDLE;
            cnt_r    <= '0;
            data_r   <= 8'h00;
            rs_r     <= 1'b0;
            long_r   <= 1'b0;
            enable_r <= 1'b0;
        end else begin
            phase_r  <= phase_n;
            cnt_r    <= cnt_n;
            data_r   <= data_n;
            rs_r     <= rs_n;
            long_r   <= long_n;
            enable_r <= enable_n;
        end
    end

endmodule

// File: rtl/lcd_display_arbiter.sv
// Round-robin arbiter that owns the HD44780 bus: power-up init, then renders each granted
// 16-bit value as '0'/'1' characters. Optional LCD_CLEAR_ON_LINE0_EN clears before line-0 text.
module lcd_display_arbiter
    import lcd_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int PULSE_CYCLES = 12,
    parameter int WAIT_CYCLES  = 2000,
    parameter int CLEAR_WAIT   = 80000
) (
    input  logic                  clock,
    input  logic                  reset,
    lcd_display_arbiter_if.slave  arb
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e         state_r, state_n;
    logic [2:0]         init_idx_r, init_idx_n;
    logic [IDX_W-1:0]   ptr_r, ptr_n;
    logic [IDX_W-1:0]   owner_r, owner_n;
    logic [15:0]        value_r, value_n;
    logic               line_r, line_n;
    logic [3:0]         bit_cnt_r, bit_cnt_n;
    logic               char_done_r, char_done_n;
    logic [NUM_REQ-1:0] grant_r, grant_n;
    logic [NUM_REQ-1:0] done_r, done_n;
    logic               busy_r, busy_n;

    logic               found_s;
    logic [IDX_W-1:0]   pick_s;
    logic               wr_start_s, wr_rs_s, wr_long_s, wr_ready_s;
    logic [7:0]         wr_data_s;

    lcd_bus_writer #(
        .PULSE_CYCLES (PULSE_CYCLES),
        .WAIT_CYCLES  (WAIT_CYCLES),
        .CLEAR_WAIT   (CLEAR_WAIT)
    ) u_writer (
        .clock     (clock),
        .reset     (reset),
        .start     (wr_start_s),
        .data      (wr_data_s),
        .rs_sel    (wr_rs_s),
        .long_wait (wr_long_s),
        .ready     (wr_ready_s),
        .enable    (arb.enable),
        .lcd_data  (arb.lcd_data),
        .rs        (arb.rs)
    );

    assign arb.grant = grant_r;
    assign arb.done  = done_r;
    assign arb.busy  = busy_r;
    assign arb.rw    = 1'b0;
    assign arb.on    = 1'b1;

    // First asserted requester at or after the pointer, wrapping around.
    always_comb begin
        int idx;
        found_s = 1'b0;
        pick_s  = '0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_r) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end else begin
                idx = idx;
            end
            if (!found_s && arb.req_valid[idx]) begin
                found_s = 1'b1;
                pick_s  = IDX_W'(idx);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state, write requests and registered-output next values.
    always_comb begin
        state_n     = state_r;
        init_idx_n  = init_idx_r;
        ptr_n       = ptr_r;
        owner_n     = owner_r;
        value_n     = value_r;
        line_n      = line_r;
        bit_cnt_n   = bit_cnt_r;
        char_done_n = char_done_r;
        grant_n     = '0;
        done_n      = '0;
        busy_n      = 1'b1;
        wr_start_s  = 1'b0;
        wr_data_s   = 8'h00;
        wr_rs_s     = 1'b0;
        wr_long_s   = 1'b0;
        case (state_r)
            ST_INIT: begin
                if (wr_ready_s) begin
                    if (init_idx_r < 3'd4) begin
                        wr_start_s = 1'b1;
                        wr_data_s  = init_cmd(init_idx_r[1:0]);
                        wr_long_s  = (init_idx_r == 3'd3);
                        init_idx_n = init_idx_r + 3'd1;
                    end else begin
                        state_n = ST_IDLE;
                        busy_n  = 1'b0;
                    end
                end else begin
                    state_n = ST_INIT;
                end
            end
            // FIN arbitrates too so a new grant can follow done immediately.
            ST_IDLE, ST_FIN: begin
                busy_n = 1'b0;
                if (found_s) begin
                    grant_n[pick_s] = 1'b1;
                    owner_n         = pick_s;
                    value_n         = arb.req_value[16*int'(pick_s) +: 16];
                    line_n          = arb.req_line[pick_s];
                    ptr_n           = (pick_s == IDX_W'(NUM_REQ - 1)) ? '0 : pick_s + IDX_W'(1);
                    busy_n          = 1'b1;
`ifdef LCD_CLEAR_ON_LINE0_EN
                    state_n         = arb.req_line[pick_s] ? ST_ADDR : ST_CLEAR;
`else
                    state_n         = ST_ADDR;
`endif
                end else begin
                    state_n = ST_IDLE;
                end
            end
`ifdef LCD_CLEAR_ON_LINE0_EN
            ST_CLEAR: begin
                if (wr_ready_s) begin
                    wr_start_s = 1'b1;
                    wr_data_s  = LCD_CMD_CLEAR;
                    wr_long_s  = 1'b1;
                    state_n    = ST_ADDR;
                end else begin
                    state_n = ST_CLEAR;
                end
            end
`endif
            ST_ADDR: begin
                if (wr_ready_s) begin
                    wr_start_s  = 1'b1;
                    wr_data_s   = line_r ? LCD_ADDR_LINE1 : LCD_ADDR_LINE0;
                    state_n     = ST_CHAR;
                    bit_cnt_n   = 4'd15;
                    char_done_n = 1'b0;
                end else begin
                    state_n = ST_ADDR;
                end
            end
            ST_CHAR: begin
                if (wr_ready_s) begin
                    if (!char_done_r) begin
                        wr_start_s = 1'b1;
                        wr_rs_s    = 1'b1;
                        wr_data_s  = bit_char(value_r[bit_cnt_r]);
                        if (bit_cnt_r == 4'd0) begin
                            char_done_n = 1'b1;
                        end else begin
                            bit_cnt_n = bit_cnt_r - 4'd1;
                        end
                    end else begin
                        state_n         = ST_FIN;
                        done_n[owner_r] = 1'b1;
                        busy_n          = 1'b0;
                    end
                end else begin
                    state_n = ST_CHAR;
                end
            end
            default: begin
                state_n    = ST_INIT;
                init_idx_n = 3'd0;
            end
        endcase
    end

    // FSM state, transaction context and registered handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_INIT;
            init_idx_r  <= 3'd0;
            ptr_r       <= '0;
            owner_r     <= '0;
            value_r     <= 16'h0000;
            line_r      <= 1'b0;
            bit_cnt_r   <= 4'd0;
            char_done_r <= 1'b0;
            grant_r     <= '0;
            done_r      <= '0;
            busy_r      <= 1'b1;
        end else begin
            state_r     <= state_n;
            init_idx_r  <= init_idx_n;
            ptr_r       <= ptr_n;
            owner_r     <= owner_n;
            value_r     <= value_n;
            line_r      <= line_n;
            bit_cnt_r   <= bit_cnt_n;
            char_done_r <= char_done_n;
            grant_r     <= grant_n;
            done_r      <= done_n;
            busy_r      <= busy_n;
        end
    end

endmodule

// File: tb/tb_lcd_display_arbiter.sv
// Directed self-checking bench for lcd_display_arbiter (PULSE=2, WAIT=4, CLEAR=10, 4 requesters).
module tb_lcd_display_arbiter;

    localparam int NREQ = 4;
`ifdef LCD_CLEAR_ON_LINE0_EN
    localparam int K0 = 1;
`else
    localparam int K0 = 0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    lcd_display_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    lcd_display_arbiter #(
        .NUM_REQ(NREQ), .PULSE_CYCLES(2), .WAIT_CYCLES(4), .CLEAR_WAIT(10)
    ) dut (
        .clock (clock),
        .reset (reset),
        .arb   (bus.slave)
    );

    always #5 clock = ~clock;

    logic [8:0] wq[$];
    int         wc[$];
    int         pl[$];
    logic [3:0] gq[$];
    int         gc[$];
    logic [3:0] dq[$];
    int         dc[$];
    int         cyc = 0;
    int         plen = 0;
    int         stable_err = 0;
    int         bf_cyc = 0;
    logic       en_prev = 1'b0;
    logic       busy_prev = 1'b1;
    logic [8:0] cur = 9'h000;

    // Bus/handshake logger sampled shortly after each rising edge.
    always begin
        @(posedge clock);
        #2;
        cyc++;
        if (bus.enable === 1'b1 && en_prev !== 1'b1) begin
            cur = {bus.rs, bus.lcd_data};
            wq.push_back(cur);
            wc.push_back(cyc);
            plen = 0;
        end
        if (bus.enable === 1'b1) begin
            plen++;
            if ({bus.rs, bus.lcd_data} !== cur) stable_err++;
        end
        if (bus.enable !== 1'b1 && en_prev === 1'b1) pl.push_back(plen);
        if (bus.grant != 4'b0000) begin gq.push_back(bus.grant); gc.push_back(cyc); end
        if (bus.done != 4'b0000) begin dq.push_back(bus.done); dc.push_back(cyc); end
        if (bus.busy === 1'b0 && busy_prev === 1'b1) bf_cyc = cyc;
        en_prev   = bus.enable;
        busy_prev = bus.busy;
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic clear_logs();
        wq.delete(); wc.delete(); pl.delete();
        gq.delete(); gc.delete(); dq.delete(); dc.delete();
    endtask

    task automatic wait_grants(input int n, input int lim);
        int k = 0;
        while (gq.size() < n && k < lim) begin @(negedge clock); k++; end
        check("grant_wait", gq.size(), n);
    endtask

    task automatic wait_dones(input int n, input int lim);
        int k = 0;
        while (dq.size() < n && k < lim) begin @(negedge clock); k++; end
        check("done_wait", dq.size(), n);
    endtask

    task automatic wait_writes(input int n, input int lim);
        int k = 0;
        while (wq.size() < n && k < lim) begin @(negedge clock); k++; end
        check("write_wait", wq.size(), n);
    endtask

    task automatic wait_idle(input int lim);
        int k = 0;
        while (bus.busy !== 1'b0 && k < lim) begin @(negedge clock); k++; end
        check("busy_wait", bus.busy, 0);
    endtask

    logic [8:0] init_exp [4] = '{9'h038, 9'h00C, 9'h006, 9'h001};
    logic [7:0] a5f0_exp [16] = '{8'h31, 8'h30, 8'h31, 8'h30, 8'h30, 8'h31, 8'h30, 8'h31,
                                 8'h31, 8'h31, 8'h31, 8'h31, 8'h30, 8'h30, 8'h30, 8'h30};
    logic [3:0] rr_exp [4] = '{4'b1000, 4'b0001, 4'b1000, 4'b0001};

    initial begin
        bus.req_valid = '0;
        bus.req_line  = '0;
        bus.req_value = '0;
        repeat (3) @(negedge clock);
        check("rst_enable", bus.enable, 0);
        check("rst_data", bus.lcd_data, 8'h00);
        check("rst_rs", bus.rs, 0);
        check("rst_rw", bus.rw, 0);
        check("rst_on", bus.on, 1);
        check("rst_grant", bus.grant, 0);
        check("rst_done", bus.done, 0);
        check("rst_busy", bus.busy, 1);

        // Power-up sequence
        clear_logs();
        reset = 1'b0;
        wait_idle(200);
        check("init_nwrites", wq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("init_w%0d", i), wq[i], init_exp[i]);
            check($sformatf("init_pulse%0d", i), pl[i], 2);
        end
        check("init_gap01", wc[1] - wc[0], 7);
        check("init_gap23", wc[3] - wc[2], 7);
        check("init_busy_len", bf_cyc - wc[0], 33);
        check("init_clear_wait", bf_cyc - wc[3], 12);

        // Single line-0 request, value changed after grant
        clear_logs();
        bus.req_line[0] = 1'b0;
        bus.req_value[15:0] = 16'hA5F0;
        bus.req_valid[0] = 1'b1;
        wait_grants(1, 50);
        check("t2_grant", gq[0], 4'b0001);
        check("t2_busy_grant", bus.busy, 1);
        bus.req_valid[0] = 1'b0;
        bus.req_value[15:0] = 16'h0000;
        wait_dones(1, 400);
        check("t2_done", dq[0], 4'b0001);
        check("t2_busy_fin", bus.busy, 0);
        check("t2_latency", dc[0] - gc[0], 120 + 13 * K0);
        check("t2_nwrites", wq.size(), 17 + K0);
`ifdef LCD_CLEAR_ON_LINE0_EN
        check("t2_clear", wq[0], 9'h001);
        check("t2_clear_gap", wc[1] - wc[0], 13);
`endif
        check("t2_addr", wq[K0], 9'h080);
        for (int i = 0; i < 16; i++)
            check($sformatf("t2_char%0d", i), wq[K0 + 1 + i], {1'b1, a5f0_exp[i]});

        // Two simultaneous requests: req1 (line 1) then req2 (line 0)
        clear_logs();
        bus.req_line[1] = 1'b1;
        bus.req_value[31:16] = 16'h0001;
        bus.req_line[2] = 1'b0;
        bus.req_value[47:32] = 16'h8000;
        bus.req_valid[2:1] = 2'b11;
        wait_grants(1, 50);
        check("t3_grant1", gq[0], 4'b0010);
        bus.req_valid[1] = 1'b0;
        wait_grants(2, 400);
        check("t3_grant2", gq[1], 4'b0100);
        bus.req_valid[2] = 1'b0;
        check("t3_done1", dq[0], 4'b0010);
        check("t3_grant_after_done", gc[1] - dc[0], 1);
        check("t3_addr1", wq[0], 9'h0C0);
        check("t3_first_char1", wq[1], 9'h130);
        check("t3_last_char1", wq[16], 9'h131);
        wait_dones(2, 400);
        check("t3_done2", dq[1], 4'b0100);
`ifdef LCD_CLEAR_ON_LINE0_EN
        check("t3_clear2", wq[17], 9'h001);
`endif
        check("t3_addr2", wq[17 + K0], 9'h080);
        check("t3_first_char2", wq[18 + K0], 9'h131);

        // Continuous req0/req3 plus a req1 pulse that drops before it is served
        clear_logs();
        bus.req_line[3] = 1'b1;
        bus.req_valid[0] = 1'b1;
        bus.req_valid[3] = 1'b1;
        wait_grants(1, 50);
        bus.req_valid[1] = 1'b1;
        repeat (3) @(negedge clock);
        bus.req_valid[1] = 1'b0;
        wait_grants(4, 800);
        bus.req_valid[0] = 1'b0;
        bus.req_valid[3] = 1'b0;
        for (int i = 0; i < 4; i++)
            check($sformatf("t4_rr%0d", i), gq[i], rr_exp[i]);
        wait_dones(4, 400);
        repeat (3) @(negedge clock);
        check("t4_no_extra_grant", gq.size(), 4);

        // Reset during the 5th character write
        clear_logs();
        bus.req_line[0] = 1'b1;
        bus.req_value[15:0] = 16'hFFFF;
        bus.req_valid[0] = 1'b1;
        wait_grants(1, 50);
        check("t5_grant", gq[0], 4'b0001);
        bus.req_valid[0] = 1'b0;
        wait_writes(6, 100);
        reset = 1'b1;
        @(negedge clock);
        check("t5_enable", bus.enable, 0);
        check("t5_grant_rst", bus.grant, 0);
        check("t5_done_rst", bus.done, 0);
        check("t5_busy_rst", bus.busy, 1);
        check("t5_data_rst", bus.lcd_data, 8'h00);
        reset = 1'b0;
        clear_logs();
        wait_idle(200);
        check("t5_init_n", wq.size(), 4);
        check("t5_init_first", wq[0], 9'h038);
        check("t5_init_last", wq[3], 9'h001);
        check("t5_no_done", dq.size(), 0);

        check("data_stable", stable_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
